// File: rtl/counter_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_sequencer_if                                          |
// | Purpose  : Command handshake bundle between a host/config agent and the  |
// |            counter_sequencer controller.                                 |
// | Signals  : cmd_valid  - command offered (host -> controller)             |
// |            cmd_ready  - controller can accept (controller -> host)       |
// |            cmd_mode   - 00 up, 01 down, 10 ping-pong, 11 reserved        |
// |            cmd_start  - first count value of each pass                   |
// |            cmd_stop   - turn/end value of each pass                      |
// |            cmd_passes - number of passes, 1..15                          |
// | Modports : master (host side), slave (controller side)                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_mode;
   logic [WIDTH-1:0] cmd_start;
   logic [WIDTH-1:0] cmd_stop;
   logic [3:0]       cmd_passes;

   modport master (
      output cmd_valid,
      output cmd_mode,
      output cmd_start,
      output cmd_stop,
      output cmd_passes,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_mode,
      input  cmd_start,
      input  cmd_stop,
      input  cmd_passes,
      output cmd_ready
   );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_sequencer                                             |
// | Purpose  : Sequencing controller for the up/down counter datapath. Takes |
// |            one command per sweep and steps a WIDTH-bit count through    |
// |            up, down or ping-pong passes, with pause, abort and          |
// |            done/err reporting.                                           |
// | Ports    : clk     - rising-edge clock                                   |
// |            rst     - synchronous reset, active low                       |
// |            cmd     - command handshake (counter_sequencer_if.slave)      |
// |            pause   - level, holds the sweep while high                   |
// |            abort   - level, terminates the sweep                         |
// |            count   - current count                                       |
// |            updown  - current direction, 1 = up                           |
// |            busy    - sweep in progress                                   |
// |            done    - one-cycle pulse at sweep end (normal or aborted)    |
// |            err     - one-cycle pulse on a rejected command               |
// | Config   : COUNTER_SEQ_PINGPONG_EN - when defined, mode 10 (ping-pong)  |
// |            is implemented; otherwise mode 10 is rejected as reserved.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module counter_sequencer #(
   parameter int WIDTH = 4,
   parameter int MAX   = 6
) (
   input  wire logic             clk,
   input  wire logic             rst,
   counter_sequencer_if.slave    cmd,
   input  wire logic             pause,
   input  wire logic             abort,
   output logic [WIDTH-1:0]      count,
   output logic                  updown,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [1:0]       MODE_UP   = 2'b00;
   localparam logic [1:0]       MODE_DOWN = 2'b01;
`ifdef COUNTER_SEQ_PINGPONG_EN
   localparam logic [1:0]       MODE_PP   = 2'b10;
`endif
   localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             updown_q, updown_d;
   logic [3:0]       remaining_q, remaining_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] stop_q, stop_d;
`ifdef COUNTER_SEQ_PINGPONG_EN
   logic [1:0]       mode_q, mode_d;
`endif
   logic             busy_q, done_q, err_q, err_d;
   logic             cmd_bad;

   // Command legality check, evaluated on the incoming command fields.
   always_comb begin
      cmd_bad = 1'b0;
      case (cmd.cmd_mode)
         MODE_UP:   cmd_bad = (cmd.cmd_start > cmd.cmd_stop);
         MODE_DOWN: cmd_bad = (cmd.cmd_start < cmd.cmd_stop);
`ifdef COUNTER_SEQ_PINGPONG_EN
         MODE_PP:   cmd_bad = (cmd.cmd_start >= cmd.cmd_stop);
`endif
         default:   cmd_bad = 1'b1;
      endcase
      if ((cmd.cmd_passes == 4'd0) || (cmd.cmd_start > MAX_V) || (cmd.cmd_stop > MAX_V)) begin
         cmd_bad = 1'b1;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      updown_d    = updown_q;
      remaining_d = remaining_q;
      start_d     = start_q;
      stop_d      = stop_q;
`ifdef COUNTER_SEQ_PINGPONG_EN
      mode_d      = mode_q;
`endif
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               if (cmd_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  count_d     = cmd.cmd_start;
                  updown_d    = (cmd.cmd_mode != MODE_DOWN);
                  remaining_d = cmd.cmd_passes;
                  start_d     = cmd.cmd_start;
                  stop_d      = cmd.cmd_stop;
`ifdef COUNTER_SEQ_PINGPONG_EN
                  mode_d      = cmd.cmd_mode;
`endif
               end
            end
         end

         RUN: begin
            if (abort) begin
               state_d = DONE;
            end else if (!pause) begin
`ifdef COUNTER_SEQ_PINGPONG_EN
               if (mode_q == MODE_PP) begin
                  // Rising leg turns at stop; falling leg ends a pass at start.
                  if (updown_q) begin
                     if (count_q == stop_q) begin
                        updown_d = 1'b0;
                        count_d  = stop_q - ONE;
                     end else begin
                        count_d = count_q + ONE;
                     end
                  end else if (count_q != start_q) begin
                     count_d = count_q - ONE;
                  end else if (remaining_q > 4'd1) begin
                     // Next pass skips start; it was the last value shown.
                     updown_d    = 1'b1;
                     count_d     = start_q + ONE;
                     remaining_d = remaining_q - 4'd1;
                  end else begin
                     state_d = DONE;
                  end
               end else
`endif
               begin
                  // updown_q already encodes up vs. down for linear modes.
                  if (count_q != stop_q) begin
                     count_d = updown_q ? (count_q + ONE) : (count_q - ONE);
                  end else if (remaining_q > 4'd1) begin
                     count_d     = start_q;
                     remaining_d = remaining_q - 4'd1;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         updown_q    <= 1'b1;
         remaining_q <= 4'd0;
         start_q     <= '0;
         stop_q      <= '0;
`ifdef COUNTER_SEQ_PINGPONG_EN
         mode_q      <= MODE_UP;
`endif
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         updown_q    <= updown_d;
         remaining_q <= remaining_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
`ifdef COUNTER_SEQ_PINGPONG_EN
         mode_q      <= mode_d;
`endif
         busy_q      <= (state_d == RUN);
         done_q      <= (state_d == DONE);
         err_q       <= err_d;
      end
   end

   // cmd_ready is the only combinational output; it is masked during reset.
   assign cmd.cmd_ready = rst && (state_q == IDLE);
   assign count         = count_q;
   assign updown        = updown_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
# counter_sequencer

- Sequencing controller for the team's parameterized up/down counter datapath.
- Accepts one command per sweep through a valid/ready handshake. Each command carries start value, stop value, direction mode and pass count.
- Steps an internal WIDTH-bit count register through the sweep, with pause, abort and done/error reporting.
- Sits between a host/config agent and any logic consuming `count`/`updown`; replaces free-running counter control.

## Interface
- WIDTH, 4, count width in bits
- MAX, 6, highest legal count value; must be ≤ 2^WIDTH−1
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_mode  in  2  00 up, 01 down, 10 ping-pong, 11 reserved
- cmd_start  in  WIDTH  first count value of each pass
- cmd_stop  in  WIDTH  turn/end value of each pass
- cmd_passes  in  4  number of passes, 1..15
- pause  in  1  level; holds the sweep while high
- abort  in  1  level; terminates the sweep
- count  out  WIDTH  current count
- updown  out  1  current direction, 1 = up
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end (normal or aborted)
- err  out  1  one-cycle pulse on rejected command

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - RUN: busy=1.
  - DONE: done=1, single cycle, always followed by IDLE.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready. It is only ever accepted in IDLE.
- Rejection conditions (err=1 next cycle, state stays IDLE, count/updown unchanged):
  - mode 11
  - passes=0
  - start>MAX or stop>MAX
  - up mode with start>stop
  - down mode with start<stop
  - ping-pong with start≥stop
- Valid accept: next cycle state=RUN, count=start, updown = 1 for up/ping-pong, 0 for down. Remaining-pass register = passes.
- RUN, per cycle, in priority order:
  1. abort → DONE; count and updown frozen.
  2. pause → hold everything.
  3. Step.
- Step, up/down modes:
  - count≠stop: move one toward stop.
  - count==stop and remaining>1: count reloads start (wrap), remaining decrements.
  - count==stop and remaining==1: → DONE.
- Step, ping-pong:
  - updown=1 and count==stop: updown←0, count←stop−1.
  - updown=0 and count==start: pass complete. If remaining>1: updown←1, count←start+1, remaining decrements. Otherwise → DONE.
- start==stop (up/down): each pass occupies exactly one RUN cycle at start.
- DONE and IDLE hold count/updown at their last RUN values until the next accepted command.
- Arithmetic is unsigned, WIDTH bits. Legal commands keep count within [0,MAX], so no overflow occurs.
- abort, pause and cmd_valid are ignored outside the states listed above.

## Timing
- Reset values (rst low at an edge): state IDLE, count=0, updown=1, busy=0, done=0, err=0.
- cmd_ready is 0 while rst is low; otherwise it equals (state==IDLE).
- Reset mid-sweep returns to IDLE in one edge. No done pulse is produced.
- All outputs except cmd_ready are registered.
- Accept→first count: 1 cycle.
- Up sweep of N values, 1 pass: busy for N cycles, done on cycle N+1, cmd_ready on cycle N+2.
- Wrap between passes costs no extra cycle.
- abort seen in RUN: done on the next cycle.
- err/done are never high together. Back-to-back commands are spaced by at least one DONE cycle.

## Configuration
- COUNTER_SEQ_PINGPONG_EN defined: mode 10 is implemented as specified.
- Not defined: mode 10 is treated as reserved (rejected with err), and the ping-pong stepping logic is compiled out.

## Test plan
- Reset, then up, start=1, stop=4, passes=1 → count 1,2,3,4 on cycles 1–4; done cycle 5; cmd_ready cycle 6.
- Down, start=5, stop=3, passes=2 → count 5,4,3,5,4,3, then done; updown=0 throughout.
- Ping-pong (macro on), start=2, stop=4, passes=1 → count 2,3,4,3,2 with updown 1,1,1,0,0; then done. Same command with macro off → err pulse; busy stays 0.
- Up 0→6, pause high for 3 cycles at count=3 → count holds 3 for 3 cycles, then 4,5,6, done. Abort at count=5 instead → done next cycle, count stays 5.
- Rejects, each giving a one-cycle err pulse and no busy:
  - stop=7 (>MAX)
  - passes=0
  - up with start=4, stop=2
  - mode 11
- rst low mid-sweep at count=3 → next cycle count=0, busy=0, no done. Also check cmd_valid held during RUN is not accepted until IDLE.
